// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into one or two 32-bit machine words with
// valid/ready handshaking on both sides and a wrapping emitted-instruction counter.
module instruction_encoder #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SIMM_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_kind,
    input  logic [2:0]       in_cond,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rq,
    input  logic [31:0]      in_imm,
    input  logic [1:0]       in_shift_type,
    input  logic [4:0]       in_shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_last,
    output logic             err_invalid,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_W0   = 2'd1;
    localparam logic [1:0] ST_EXT  = 2'd2;

    localparam logic [2:0] KIND_RRR    = 3'd0;
    localparam logic [2:0] KIND_RRI    = 3'd1;
    localparam logic [2:0] KIND_MEMORY = 3'd2;
    localparam logic [2:0] KIND_MODEL  = 3'd3;
    localparam logic [2:0] KIND_CUSTOM = 3'd4;

    localparam logic [4:0] OP_RESERVED = 5'h1f;

    logic [1:0]       state_q;
    logic [31:0]      word_q;
    logic             last_q;
    logic [31:0]      ext_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    logic [32-SIMM_W:0] imm_hi;
    logic               imm_fits;
    logic [4:0]         enc_a;
    logic [4:0]         enc_b;
    logic               enc_x;
    logic [31:0]        enc_ext;
    logic               enc_drop;
    logic [31:0]        enc_word0;
    logic               handshake;
    logic               accept;

    // Inline form only when bits above the signed immediate are a pure sign extension.
    assign imm_hi   = in_imm[31:SIMM_W-1];
    assign imm_fits = (&imm_hi) | ~(|imm_hi);

    always_comb begin
        enc_a    = '0;
        enc_b    = '0;
        enc_x    = 1'b0;
        enc_ext  = '0;
        enc_drop = 1'b0;
        case (in_kind)
            KIND_RRR: begin
                enc_drop = (in_op == OP_RESERVED);
                enc_a    = in_rq;
                enc_b    = in_shift_amt;
                enc_x    = (in_shift_type != 2'b00);
                enc_ext  = {30'b0, in_shift_type};
            end
            KIND_RRI, KIND_MEMORY: begin
                enc_drop = (in_kind == KIND_MEMORY) && (in_op == OP_RESERVED);
                if (imm_fits) begin
                    enc_a = in_imm[9:5];
                    enc_b = in_imm[4:0];
                end else begin
                    enc_x   = 1'b1;
                    enc_ext = in_imm;
                end
            end
            KIND_MODEL: begin
                enc_a = in_rq;
            end
            KIND_CUSTOM: begin
                enc_a   = in_rq;
                enc_x   = 1'b1;
                enc_ext = in_imm;
            end
            default: enc_drop = 1'b1;
        endcase
    end

    assign enc_word0 = {in_kind, in_cond, in_op, in_rd, in_rs, enc_a, enc_x, enc_b};

    assign out_valid   = (state_q != ST_IDLE);
    assign out_word    = word_q;
    assign out_last    = last_q;
    assign err_invalid = err_q;
    assign instr_count = count_q;

    assign handshake = out_valid & out_ready;
    // Accepting on the final handshake keeps back-to-back instructions bubble-free.
    assign in_ready  = (state_q == ST_IDLE) | (handshake & last_q);
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            last_q  <= 1'b0;
            ext_q   <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            err_q <= accept & enc_drop;
            if (handshake && last_q) begin
                count_q <= count_q + CNT_W'(1);
            end
            // In W0, a pending ext word is signalled by last_q being clear.
            if (handshake && (state_q == ST_W0) && !last_q) begin
                state_q <= ST_EXT;
                word_q  <= ext_q;
                last_q  <= 1'b1;
            end else if (accept && !enc_drop) begin
                state_q <= ST_W0;
                word_q  <= enc_word0;
                last_q  <= ~enc_x;
                ext_q   <= enc_ext;
            end else if (handshake) begin
                state_q <= ST_IDLE;
            end
        end
    end

endmodule
